// File: rtl/jtvigil_scrpl.sv
// jtvigil_scrpl: scroll-plane pixel fetcher.
// Adds the horizontal scroll to the pixel counter, prefetches the next ROM word
// through a cs/ok handshake and serialises the packed pixels, with optional flip.
// Optional vertical scroll input is enabled with JTVIGIL_SCR_VSCROLL_EN.
module jtvigil_scrpl #(
  parameter  int PW    = 4,
  parameter  int DW    = 32,
  parameter  int SW    = 11,
  parameter  int TW    = 9,
  parameter  int VW    = 8,
  parameter  int ALIGN = 2,
  localparam int PPW   = DW / PW,
  localparam int WB    = $clog2(PPW),
  localparam int AW    = (SW - TW) + VW + (TW - WB) + ALIGN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          flip,
  input  logic [8:0]    h,
  input  logic [8:0]    v,
  input  logic [SW-1:0] scrpos,
`ifdef JTVIGIL_SCR_VSCROLL_EN
  input  logic [VW-1:0] vscr,
`endif
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [DW-1:0] rom_data,
  output logic          miss,
  output logic [PW-1:0] pxl
);

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, DONE} state_t;

  state_t        r_st, w_st_nxt;
  logic [SW-1:0] r_hsum;
  logic [WB-1:0] r_kidx;
  logic [DW-1:0] r_buf, r_shift;
  logic          r_valid, r_miss;
  logic [PW-1:0] r_pxl;
  logic [AW-1:0] r_addr;

  logic          w_tick, w_issue, w_take;
  logic [SW-1:0] w_hpos, w_hnext;
  logic [VW-1:0] w_vrow;
  logic [AW-1:0] w_addr;
  logic [WB-1:0] w_k;
  logic [PW-1:0] w_pix;
  logic [PW-1:0] w_cand [PPW];
  logic          w_unused;

  assign w_unused = ^v;

  assign w_tick  = pxl_cen && (r_hsum[WB-1:0] == '0);
  // IDLE is only reachable through reset, so any pxl_cen there starts fetching
  assign w_issue = w_tick || (pxl_cen && (r_st == IDLE));
  // data arriving on the same clock as a new request belongs to the old word
  assign w_take  = (r_st == WAIT) && rom_ok && !w_issue;

  assign w_hpos  = SW'(h) + scrpos;
  assign w_hnext = r_hsum + SW'(PPW);
`ifdef JTVIGIL_SCR_VSCROLL_EN
  assign w_vrow  = v[VW-1:0] + vscr;
`else
  assign w_vrow  = v[VW-1:0];
`endif
  assign w_addr  = AW'({w_hnext[SW-1:TW], w_vrow, w_hnext[TW-1:WB]}) << ALIGN;

  // pixel k takes plane j from bit 2j (even k) or 2j+1 (odd k) of group k/2
  for (genvar k = 0; k < PPW; k++) begin : g_pix
    for (genvar j = 0; j < PW; j++) begin : g_plane
      assign w_cand[k][j] = r_shift[(k / 2) * 2 * PW + 2 * j + (k % 2)];
    end
  end

  assign w_k   = flip ? ~r_kidx : r_kidx;
  assign w_pix = w_cand[w_k];

  assign rom_addr = r_addr;
  assign miss     = r_miss;
  assign pxl      = r_pxl;

  // fetch FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_st <= IDLE;
    else     r_st <= w_st_nxt;
  end

  // fetch FSM next state and request strobe
  always_comb begin
    w_st_nxt = r_st;
    rom_cs   = (r_st == SETTLE) || (r_st == WAIT);
    if (w_issue) begin
      w_st_nxt = SETTLE;
    end else begin
      case (r_st)
        SETTLE:  w_st_nxt = WAIT;
        WAIT:    if (rom_ok) w_st_nxt = DONE;
        default: w_st_nxt = r_st;
      endcase
    end
  end

  // scroll position, word buffer, pixel output and miss flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsum  <= '0;
      r_kidx  <= '0;
      r_buf   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_miss  <= 1'b0;
      r_pxl   <= '0;
      r_addr  <= '0;
    end else begin
      if (pxl_cen) begin
        r_hsum <= w_hpos;
        r_kidx <= r_hsum[WB-1:0];
        r_miss <= w_tick && !r_valid;
        r_pxl  <= w_pix;
      end
      if (w_issue) r_addr <= w_addr;
      if (w_tick) begin
        r_shift <= r_valid ? r_buf : '0;
        r_valid <= 1'b0;
      end else if (w_take) begin
        r_buf   <= rom_data;
        r_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtvigil_scrpl.sv
// Self-checking bench for jtvigil_scrpl with a behavioural ROM responder and
// a column-level reference model of the scroll plane.
module tb_jtvigil_scrpl;

  logic        clk;
  logic        rst;
  logic        pxl_cen;
  logic        flip;
  logic [8:0]  h;
  logic [8:0]  v;
  logic [10:0] scrpos;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic        rom_ok;
  logic [31:0] rom_data;
  logic        miss;
  logic [3:0]  pxl;
`ifdef JTVIGIL_SCR_VSCROLL_EN
  logic [7:0]  vscr;
`endif

  jtvigil_scrpl dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .flip     (flip),
    .h        (h),
    .v        (v),
    .scrpos   (scrpos),
`ifdef JTVIGIL_SCR_VSCROLL_EN
    .vscr     (vscr),
`endif
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_ok   (rom_ok),
    .rom_data (rom_data),
    .miss     (miss),
    .pxl      (pxl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // reference model state
  int unsigned m_hsum, m_k, m_faddr, m_issue;
  logic [31:0] m_word;
  bit          m_have, m_bnd;
  int unsigned late_idx = 32'd1000000;
  bit          ok_always = 1'b0;
  // ROM responder state
  int unsigned rsp_cnt;
  logic [17:0] rsp_prev;
  int unsigned hv;

  function automatic logic [31:0] rom_fn(input int unsigned a);
    return (a * 32'h9E3779B1) ^ (a << 13) ^ 32'h13579BDF;
  endfunction

  function automatic int unsigned addr_fn(input int unsigned hn, input int unsigned row);
    int unsigned x;
    x = hn % 2048;
    return (x / 512) * 65536 + (row % 256) * 256 + ((x / 8) % 64) * 4;
  endfunction

  function automatic int unsigned pix_of(input logic [31:0] w, input int unsigned k);
    int unsigned p;
    p = 0;
    for (int unsigned j = 0; j < 4; j++)
      if (((w >> ((k / 2) * 8 + 2 * j + (k % 2))) & 32'd1) != 0) p += (1 << j);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hsum = 0; m_k = 0; m_faddr = 0; m_word = '0; m_have = 1'b0; m_bnd = 1'b0;
  endtask

  // one pixel-clock event: what the plane must show, derived column by column
  task automatic model_cen();
    int unsigned exp_pxl, row, kk;
    bit exp_miss;
    kk = flip ? (7 - m_k) : m_k;
    exp_pxl  = pix_of(m_word, kk);
    m_bnd    = (m_hsum % 8) == 0;
    exp_miss = m_bnd && !m_have;
`ifdef JTVIGIL_SCR_VSCROLL_EN
    row = (32'(v) + 32'(vscr)) % 256;
`else
    row = 32'(v) % 256;
`endif
    if (m_bnd) begin
      m_word  = m_have ? rom_fn(m_faddr) : 32'd0;
      m_faddr = addr_fn(m_hsum + 8, row);
      m_have  = (m_issue != late_idx);
      m_issue++;
      chk("rom_addr", 32'(rom_addr), m_faddr);
      chk("rom_cs_req", 32'(rom_cs), 32'd1);
    end
    m_k    = m_hsum % 8;
    m_hsum = (32'(h) + 32'(scrpos)) % 2048;
    chk("pxl", 32'(pxl), exp_pxl);
    chk("miss", 32'(miss), 32'(exp_miss));
  endtask

  // ROM slot: data follows the address with one clock of lag; ok after 2 clk of cs
  task automatic responder();
    rom_data = rom_fn(32'(rsp_prev));
    if (!rom_cs || rom_addr != rsp_prev) rsp_cnt = rom_cs ? 1 : 0;
    else rsp_cnt++;
    rsp_prev = rom_addr;
    rom_ok = ok_always || (rom_cs && rsp_cnt >= 2 && m_issue != late_idx + 1);
  endtask

  task automatic step(input bit cen);
    pxl_cen = cen;
    @(posedge clk);
    #1;
    if (cen && !rst) model_cen();
    responder();
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    for (int unsigned i = 0; i < n; i++) step(i % 2 == 0);
    chk("rst_pxl", 32'(pxl), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_cs", 32'(rom_cs), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    model_reset();
    hv = 0;
  endtask

  // mode: 0 flip=0, 1 flip=1, 2 random flip per pixel
  task automatic run_cens(input int unsigned n, input int unsigned mode);
    for (int unsigned i = 0; i < n; i++) begin
      h = 9'(hv);
      hv = (hv + 1) % 512;
      flip = (mode == 2) ? 1'($urandom) : (mode == 1);
      step(1'b1);
      repeat ($urandom_range(2, 4)) step(1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; flip = 1'b0; h = '0; v = '0; scrpos = '0;
    rom_ok = 1'b0; rom_data = '0; rsp_cnt = 0; rsp_prev = '0; m_issue = 0; hv = 0;
`ifdef JTVIGIL_SCR_VSCROLL_EN
    vscr = '0;
`endif
    model_reset();

    do_reset(3);

    // sequential scan, fixed scroll, normal orientation then flipped
    scrpos = 11'h205; v = 9'h013;
    run_cens(64, 0);
    run_cens(64, 1);

    // random scroll, rows and per-pixel flip
    scrpos = 11'($urandom); v = 9'($urandom);
`ifdef JTVIGIL_SCR_VSCROLL_EN
    vscr = 8'($urandom);
`endif
    for (int unsigned s = 0; s < 8; s++) begin
      v = 9'($urandom);
      run_cens(16, 2);
    end

    // rom_ok held high: stale data must never be latched
    ok_always = 1'b1;
    run_cens(64, 2);
    ok_always = 1'b0;

    // one request withheld past its boundary
    late_idx = m_issue + 1;
    run_cens(40, 0);
    late_idx = 32'd1000000;

    // scroll wrap across the top of the position range
    do_reset(3);
    scrpos = 11'h7FC; v = 9'h0A5;
    run_cens(32, 0);

    // reset while a request is outstanding
    for (int unsigned i = 0; i < 16; i++) begin
      h = 9'(hv); hv = (hv + 1) % 512;
      step(1'b1);
      if (m_bnd) break;
      repeat (2) step(1'b0);
    end
    step(1'b0);
    chk("wait_cs", 32'(rom_cs), 32'd1);
    rst = 1'b1;
    step(1'b1);
    chk("midrst_cs", 32'(rom_cs), 32'd0);
    chk("midrst_addr", 32'(rom_addr), 32'd0);
    chk("midrst_pxl", 32'(pxl), 32'd0);
    chk("midrst_miss", 32'(miss), 32'd0);
    rst = 1'b0;
    model_reset();
    hv = 0;
    scrpos = 11'($urandom);
    run_cens(24, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, required $finish");
    $fatal(1, "simulation time limit");
  end

endmodule
